// File: rtl/serial_rx_deframer_pkg.sv
// Shared definitions for the serial link: receiver FSM states and line-level constants.
package serial_rx_deframer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_rx_hold_reg.sv
// Valid/ready holding register for deframed words; flags a good word that arrives while full.
module serial_rx_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              deliver_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // Next-state: a same-cycle pop makes room for the incoming word.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (deliver_i) begin
      if (!valid_q || ready_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_rx_deframer.sv
// Serial receiver: deframes start/data/parity/stop frames into words behind a holding register.
module serial_rx_deframer
  import serial_rx_deframer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              rx_sclk_i,
  input  logic              rx_srst_i,
  input  logic              rx_sdata_i,
  output logic [DATA_W-1:0] rx_pdata_o,
  output logic              rx_pdata_valid_o,
  input  logic              rx_pdata_ready_i,
  output logic              rx_frame_err_o,
  output logic              rx_parity_err_o,
  output logic              rx_overrun_o,
  output logic              rx_busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sd_q, sd_d;
  logic              par_bad_q, par_bad_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              deliver;

  // Frame sequencing; the FSM only ever looks at the registered line sample.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    sd_d         = rx_sdata_i;
    par_bad_d    = par_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    deliver      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sd_q == START_BIT) begin
          state_d   = DATA;
          cnt_d     = '0;
          par_bad_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        shift_d = {sd_q, shift_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        par_bad_d = (sd_q != calc_parity(shift_q, PARITY_ODD));
        state_d   = STOP;
      end
      STOP: begin
        if (sd_q == STOP_BIT) begin
          // Parity errors only surface on an otherwise well-framed word.
          if (par_bad_q) begin
            parity_err_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        if (sd_q == IDLE_LEVEL) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge rx_sclk_i) begin
    if (rx_srst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      sd_q         <= IDLE_LEVEL;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      sd_q         <= sd_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  serial_rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk_i     (rx_sclk_i),
    .srst_i    (rx_srst_i),
    .deliver_i (deliver),
    .word_i    (shift_q),
    .ready_i   (rx_pdata_ready_i),
    .data_o    (rx_pdata_o),
    .valid_o   (rx_pdata_valid_o),
    .overrun_o (rx_overrun_o)
  );

  assign rx_frame_err_o  = frame_err_q;
  assign rx_parity_err_o = parity_err_q;
  assign rx_busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed bench for serial_rx_deframer (DATA_W=8, even parity enabled).
module tb_serial_rx_deframer;

  logic       clk = 1'b0;
  logic       srst;
  logic       sdata;
  logic [7:0] pdata;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int nvec = 0;
  int nmis = 0;

  serial_rx_deframer #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .rx_sclk_i        (clk),
    .rx_srst_i        (srst),
    .rx_sdata_i       (sdata),
    .rx_pdata_o       (pdata),
    .rx_pdata_valid_o (valid),
    .rx_pdata_ready_i (ready),
    .rx_frame_err_o   (frame_err),
    .rx_parity_err_o  (parity_err),
    .rx_overrun_o     (overrun),
    .rx_busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit for exactly one rising edge, then settle past the edge.
  task automatic send_bit(input logic b);
    sdata = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ flip);
    send_bit(stop);
  endtask

  initial begin
    srst  = 1'b1;
    sdata = 1'b1;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_pdata", pdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {frame_err, parity_err, overrun}, 3'b000);
    srst = 1'b0;
    send_bit(1'b1);

    // Good frame 0xC5.
    send_frame(8'hC5, 1'b0, 1'b1);
    send_bit(1'b1);
    check("c5_valid", valid, 1'b1);
    check("c5_pdata", pdata, 8'hC5);
    check("c5_errs", {frame_err, parity_err, overrun}, 3'b000);
    check("c5_busy", busy, 1'b0);
    send_bit(1'b1);
    check("c5_valid_1cyc", valid, 1'b0);
    check("c5_pdata_hold", pdata, 8'hC5);

    // Parity bit flipped.
    send_frame(8'hC5, 1'b1, 1'b1);
    send_bit(1'b1);
    check("par_pulse", parity_err, 1'b1);
    check("par_valid", valid, 1'b0);
    check("par_frame", frame_err, 1'b0);
    send_bit(1'b1);
    check("par_once", parity_err, 1'b0);

    // Stop bit 0 followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b0);
    check("frm_pulse", frame_err, 1'b1);
    check("frm_par_supp", parity_err, 1'b0);
    check("frm_valid", valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0);
      check("frm_once", frame_err, 1'b0);
      check("brk_busy", busy, 1'b1);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    check("brk_exit", busy, 1'b0);
    check("brk_nostart", valid, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    check("a5_valid", valid, 1'b1);
    check("a5_pdata", pdata, 8'hA5);
    send_bit(1'b1);

    // Overrun: ready low, back-to-back frames.
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_bit(1'b1);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_pdata", pdata, 8'h11);
    check("ovr_valid", valid, 1'b1);
    send_bit(1'b1);
    check("ovr_once", overrun, 1'b0);
    check("ovr_valid_hold", valid, 1'b1);
    ready = 1'b1;
    send_bit(1'b1);
    check("ovr_pop", valid, 1'b0);
    check("ovr_pdata_kept", pdata, 8'h11);

    // Pop and deliver in the same cycle.
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    ready = 1'b1;
    send_bit(1'b1);
    check("swap_pdata", pdata, 8'h22);
    check("swap_valid", valid, 1'b1);
    check("swap_no_ovr", overrun, 1'b0);
    send_bit(1'b1);
    check("swap_pop", valid, 1'b0);

    // Reset mid-frame with a full holding register.
    ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1);
    send_bit(1'b1);
    check("pre_rst_valid", valid, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("mid_busy", busy, 1'b1);
    srst = 1'b1;
    send_bit(1'b1);
    srst = 1'b0;
    check("mrst_valid", valid, 1'b0);
    check("mrst_pdata", pdata, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_errs", {frame_err, parity_err, overrun}, 3'b000);
    ready = 1'b1;
    send_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_bit(1'b1);
    check("5a_valid", valid, 1'b1);
    check("5a_pdata", pdata, 8'h5A);
    check("5a_errs", {frame_err, parity_err, overrun}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/serial_rx_deframer.md
Name: serial_rx_deframer

Overview:
- Receive end of the serial link driven by the transmit side: deframes a one-bit-per-clock serial stream on rx_sclk_i into parallel words.
- Frame: start bit (0), DATA_W data bits LSB first, optional parity bit, stop bit (1). Line idles high.
- Each completed word is presented on a valid/ready holding register toward the parallel domain logic.
- Flags framing, parity and overrun conditions as single-cycle pulses.

Parameters:
- DATA_W, 8, data bits per frame.
- PARITY_EN, 1, 1 = parity bit present between last data bit and stop bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- rx_sclk_i  input  1  serial clock; all logic on its rising edge.
- rx_srst_i  input  1  synchronous reset, active-high.
- rx_sdata_i  input  1  serial line, idle high.
- rx_pdata_o  output  DATA_W  received word; valid only while rx_pdata_valid_o=1.
- rx_pdata_valid_o  output  1  holding register full.
- rx_pdata_ready_i  input  1  consumer accepts the word when valid&ready at a rising edge.
- rx_frame_err_o  output  1  one-cycle pulse when the stop bit is sampled 0.
- rx_parity_err_o  output  1  one-cycle pulse on parity mismatch.
- rx_overrun_o  output  1  one-cycle pulse when a good word is dropped because the holding register is full.
- rx_busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rx_srst_i=1 at a rising edge): state=IDLE, bit counter=0, shift register=0, rx_pdata_o=0, rx_pdata_valid_o=0, all error pulses=0, rx_busy_o=0, input register=1.
- Reset mid-frame aborts the frame. No flag is raised and the holding register is cleared.
- Input register: rx_sdata_i is registered once into sd_q. The FSM acts only on sd_q.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
  - IDLE: sd_q=0 -> DATA, counter=0. Otherwise stay.
  - DATA: shift sd_q into the MSB of the shift register (right shift, so the LSB-first stream lands in bit order) and increment the counter. After DATA_W bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: compare sd_q against the computed parity (even: XOR of the data bits; odd: its inverse). Latch the mismatch flag -> STOP.
  - STOP: if sd_q=1 and no parity mismatch, deliver the word -> IDLE.
    - If sd_q=1 with a parity mismatch: pulse rx_parity_err_o, discard the word -> IDLE.
    - If sd_q=0: pulse rx_frame_err_o, discard the word (the parity flag is suppressed) -> BREAK.
  - BREAK: wait for sd_q=1 -> IDLE. No start bit is recognised while the line is held low.
- Latency: if the stop bit is on rx_sdata_i at rising edge N, rx_pdata_valid_o and any error pulse are high after edge N+1. Back-to-back frames (stop bit directly followed by a start bit) are supported with no idle bit.
- Holding register:
  - Deliver with valid=0: load the word, set valid.
  - valid&ready with no delivery: clear valid.
  - Deliver while valid&ready in the same cycle: load the new word, valid stays 1.
  - Deliver while valid&!ready: keep the old word, pulse rx_overrun_o, drop the new word.
  - rx_pdata_o holds its value while valid=0.
- Widths: counter is clog2(DATA_W+1) bits; no wrap beyond DATA_W.

Decomposition:
- Shared package holds: the state enum (IDLE, DATA, PARITY, STOP, BREAK), START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1. The transmit side reuses these constants.
- One sub-module: serial_rx_hold_reg, containing the valid/ready holding register and overrun detection.
- FSM, shifter and parity logic stay in the top module.

Test Plan:
- Reset, then send 8'd197 (line bits 0,1,0,1,0,0,0,1,1,0,1: start, data LSB first, even parity 0, stop) with ready=1 -> rx_pdata_o=8'hC5, valid high for 1 cycle at N+1, no error pulses.
- Same frame with the parity bit flipped to 1 -> rx_parity_err_o pulses once, valid stays 0.
- Frame 8'h3C with stop bit 0 and the line held low for 5 cycles -> rx_frame_err_o pulses once; no new frame starts until the line goes high; next frame 8'hA5 received correctly.
- ready=0, two back-to-back frames 8'h11 then 8'h22 -> rx_pdata_o stays 8'h11, rx_overrun_o pulses at the second stop+1; asserting ready then clears valid.
- Raise ready in the same cycle the second word delivers -> rx_pdata_o=8'h22, valid remains 1, no overrun.
- Assert rx_srst_i during data bit 4 of a frame -> all outputs 0, rx_busy_o=0; the following clean frame 8'h5A is received correctly.
